cla_share_arb: RTL and testbench

Shares the single 48-bit carry-lookahead final adder (`CLA_module`) between NREQ requesters, such as the FP multiplier mantissa path and the FP adder mantissa path.
- Each requester offers a sum/carry operand pair through a valid/ready handshake.
- The block grants one request per cycle and drives the winner's operands into the CLA.
- A tag travels alongside each operation through the CLA latency.
- The result and carry-out are held per requester until that requester accepts them.

---
 rtl/cla_share_pkg.sv | 18 +
 rtl/cla_rr_arb.sv | 58 +++++
 rtl/cla_share_arb.sv | 119 +++++++++++
 tb/tb_cla_share_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_share_pkg.sv
// Shared types for the CLA final-adder sharing arbiter: requester state, tag payload, widths.
package cla_share_pkg;

  localparam int unsigned CLA_WIDTH = 48;
  localparam int unsigned TAG_IDX_W = 2;  // covers up to 4 requesters

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } req_state_e;

  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } cla_tag_t;

endpackage

// File: rtl/cla_rr_arb.sv
// One-hot request picker for the shared CLA: round-robin by default,
// lowest-index fixed priority when CLA_SHARE_ARB_FIXED_PRIO_EN is defined.
module cla_rr_arb #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDXW = $clog2(NREQ)
) (
`ifndef CLA_SHARE_ARB_FIXED_PRIO_EN
  input  logic            clk,
  input  logic            nreset,
`endif
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_vld
);

  logic [IDXW-1:0] cand;

`ifndef CLA_SHARE_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0] ptr_q;

  // Position 'off' steps after the pointer, wrapping at NREQ.
  function automatic logic [IDXW-1:0] rot(input logic [IDXW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDXW'(s);
  endfunction

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q <= '0;
    end else if (grant_vld) begin
      ptr_q <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);
    end
  end
`endif

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef CLA_SHARE_ARB_FIXED_PRIO_EN
      cand = IDXW'(i);
`else
      cand = rot(ptr_q, i);
`endif
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/cla_share_arb.sv
// Shares one pipelined CLA final adder between NREQ requesters; per-requester result holding.
// Arbitration policy selected by CLA_SHARE_ARB_FIXED_PRIO_EN (defined: fixed priority).
module cla_share_arb
  import cla_share_pkg::*;
#(
  parameter int unsigned WIDTH   = CLA_WIDTH,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned CLA_LAT = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_s,
  input  logic [NREQ*WIDTH-1:0] req_c,
  output logic [NREQ-1:0]       res_valid,
  input  logic [NREQ-1:0]       res_ready,
  output logic [NREQ*WIDTH-1:0] res_sum,
  output logic [NREQ-1:0]       res_cout,
  output logic [WIDTH-1:0]      cla_s,
  output logic [WIDTH-1:0]      cla_c,
  input  logic [WIDTH-1:0]      cla_sum,
  input  logic                  cla_cout
);

  localparam int unsigned IDXW = $clog2(NREQ);

  req_state_e      state_q [NREQ];
  req_state_e      state_d [NREQ];
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_vld;
  logic [NREQ-1:0] cap;
  cla_tag_t        tag_q [CLA_LAT];
  cla_tag_t        tag_out;

  cla_rr_arb #(.NREQ(NREQ)) u_arb (
`ifndef CLA_SHARE_ARB_FIXED_PRIO_EN
    .clk       (clk),
    .nreset    (nreset),
`endif
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;
  assign tag_out   = tag_q[CLA_LAT-1];

  // One outstanding op per requester: a DONE slot frees up only when its result is consumed.
  always_comb begin
    eligible = '0;
    cap      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      eligible[k] = req_valid[k] &&
                    ((state_q[k] == ST_IDLE) || ((state_q[k] == ST_DONE) && res_ready[k]));
      cap[k]      = tag_out.vld && (tag_out.idx == TAG_IDX_W'(k));
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned k = 0; k < NREQ; k++) state_q[k] <= ST_IDLE;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) state_q[k] <= state_d[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_IDLE: if (grant[k]) state_d[k] = ST_BUSY;
        ST_BUSY: if (cap[k])   state_d[k] = ST_DONE;
        ST_DONE: if (res_ready[k]) state_d[k] = grant[k] ? ST_BUSY : ST_IDLE;
        default: state_d[k] = ST_IDLE;
      endcase
    end
  end

  // Operand registers and tag pipe tracking which requester owns each CLA stage.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cla_s <= '0;
      cla_c <= '0;
      for (int unsigned i = 0; i < CLA_LAT; i++) tag_q[i] <= '0;
    end else begin
      if (grant_vld) begin
        cla_s <= req_s[32'(grant_idx) * WIDTH +: WIDTH];
        cla_c <= req_c[32'(grant_idx) * WIDTH +: WIDTH];
      end
      tag_q[0].vld <= grant_vld;
      tag_q[0].idx <= TAG_IDX_W'(grant_idx);
      for (int unsigned i = 1; i < CLA_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Result holding: capture sets valid (owner is BUSY then), consume clears it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      res_valid <= '0;
      res_sum   <= '0;
      res_cout  <= '0;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (cap[k]) begin
          res_valid[k]               <= 1'b1;
          res_sum[k*WIDTH +: WIDTH]  <= cla_sum;
          res_cout[k]                <= cla_cout;
        end else if (res_ready[k]) begin
          res_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_share_arb.sv
// Directed self-checking bench for cla_share_arb with a one-register pipelined CLA model.
module tb_cla_share_arb;

  localparam int unsigned WIDTH   = 48;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned CLA_LAT = 2;

  logic                  clk = 1'b0;
  logic                  nreset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_s;
  logic [NREQ*WIDTH-1:0] req_c;
  logic [NREQ-1:0]       res_valid;
  logic [NREQ-1:0]       res_ready;
  logic [NREQ*WIDTH-1:0] res_sum;
  logic [NREQ-1:0]       res_cout;
  logic [WIDTH-1:0]      cla_s;
  logic [WIDTH-1:0]      cla_c;
  logic [WIDTH-1:0]      cla_sum;
  logic                  cla_cout;
  logic [WIDTH:0]        cla_pipe;

  int n_checks = 0;
  int n_fail   = 0;
  int n_gnt0;
  logic [1:0] pat [3];

  always #5 clk = ~clk;

  // CLA stand-in: CLA_LAT=2 means one register after the DUT's operand register.
  always_ff @(posedge clk) cla_pipe <= {1'b0, cla_s} + {1'b0, cla_c};
  assign cla_sum  = cla_pipe[WIDTH-1:0];
  assign cla_cout = cla_pipe[WIDTH];

  cla_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .CLA_LAT(CLA_LAT)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_s     (req_s),
    .req_c     (req_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .cla_s     (cla_s),
    .cla_c     (cla_c),
    .cla_sum   (cla_sum),
    .cla_cout  (cla_cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset    = 1'b0;
    req_valid = '0;
    res_ready = '0;
    req_s     = '0;
    req_c     = '0;
    step();
    step();
    nreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pat[0] = 2'b01;
    pat[1] = 2'b10;
    pat[2] = 2'b00;

    // Reset values
    do_reset();
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_res_valid", 64'(res_valid), 64'h0);
    check("rst_res_sum0",  64'(res_sum[47:0]), 64'h0);
    check("rst_res_sum1",  64'(res_sum[95:48]), 64'h0);
    check("rst_res_cout",  64'(res_cout), 64'h0);
    check("rst_cla_s",     64'(cla_s), 64'h0);
    check("rst_cla_c",     64'(cla_c), 64'h0);

    // 1: single request
    req_valid   = 2'b01;
    req_s[47:0] = 48'h123456789ABC;
    req_c[47:0] = 48'hFEDCBA987654;
    #1;
    check("t1_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    check("t1_cla_s", 64'(cla_s), 64'h123456789ABC);
    check("t1_cla_c", 64'(cla_c), 64'hFEDCBA987654);
    step();
    check("t1_not_yet", 64'(res_valid), 64'h0);
    step();
    check("t1_valid", 64'(res_valid), 64'h1);
    check("t1_sum",   64'(res_sum[47:0]), 64'h111111111110);
    check("t1_cout",  64'(res_cout[0]), 64'h1);
    res_ready = 2'b01;
    step();
    check("t1_consumed", 64'(res_valid), 64'h0);

    // 2: simultaneous requests from reset
    do_reset();
    req_valid    = 2'b11;
    req_s[47:0]  = 48'h0F0F0F0F0F0F;
    req_c[47:0]  = 48'hF0F0F0F0F0F0;
    req_s[95:48] = 48'hAAAAAAAAAAAA;
    req_c[95:48] = 48'h555555555555;
    #1;
    check("t2_gnt_first", 64'(req_ready), 64'h1);
    step();
    check("t2_gnt_second", 64'(req_ready), 64'h2);
    step();
    check("t2_gnt_none", 64'(req_ready), 64'h0);
    req_valid = 2'b00;
    step();
    check("t2_valid0", 64'(res_valid), 64'h1);
    check("t2_sum0",   64'(res_sum[47:0]), 64'hFFFFFFFFFFFF);
    check("t2_cout0",  64'(res_cout[0]), 64'h0);
    step();
    check("t2_valid01", 64'(res_valid), 64'h3);
    check("t2_sum1",    64'(res_sum[95:48]), 64'hFFFFFFFFFFFF);
    check("t2_cout1",   64'(res_cout[1]), 64'h0);

    // 3: backpressure on requester 1 while requester 0 keeps flowing
    res_ready    = 2'b01;
    req_valid    = 2'b11;
    req_s[47:0]  = 48'h000000000001;
    req_c[47:0]  = 48'h000000000002;
    req_s[95:48] = 48'h111111111111;
    req_c[95:48] = 48'h222222222222;
    #1;
    check("t3_gnt0", 64'(req_ready), 64'h1);
    n_gnt0 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t3_hold_sum1_%0d", i), 64'(res_sum[95:48]), 64'hFFFFFFFFFFFF);
      check($sformatf("t3_hold_vld1_%0d", i), 64'(res_valid[1]), 64'h1);
      check($sformatf("t3_no_gnt1_%0d", i), 64'(req_ready[1]), 64'h0);
      if (req_ready[0]) n_gnt0++;
    end
    check("t3_gnt0_count", 64'(n_gnt0), 64'd3);
    check("t3_sum0", 64'(res_sum[47:0]), 64'h3);
    res_ready = 2'b11;
    req_valid = 2'b10;
    #1;
    check("t3_gnt1_released", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b00;
    step();
    step();
    check("t3_valid1", 64'(res_valid[1]), 64'h1);
    check("t3_sum1",   64'(res_sum[95:48]), 64'h333333333333);
    step();
    check("t3_drained", 64'(res_valid), 64'h0);

    // 4: same-cycle consume and reissue
    res_ready   = 2'b00;
    req_valid   = 2'b01;
    req_s[47:0] = 48'h000000000001;
    req_c[47:0] = 48'h000000000001;
    #1;
    check("t4_gnt_a", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    step();
    step();
    check("t4_valid_a", 64'(res_valid), 64'h1);
    check("t4_sum_a",   64'(res_sum[47:0]), 64'h2);
    res_ready   = 2'b01;
    req_valid   = 2'b01;
    req_s[47:0] = 48'hDEADBEEFCAFE;
    req_c[47:0] = 48'h0123456789AB;
    #1;
    check("t4_gnt_reissue", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    check("t4_cleared", 64'(res_valid), 64'h0);
    step();
    step();
    check("t4_valid_b", 64'(res_valid), 64'h1);
    check("t4_sum_b",   64'(res_sum[47:0]), 64'hDFD1045754A9);
    check("t4_cout_b",  64'(res_cout[0]), 64'h0);
    step();

    // 5: reset one cycle after a grant
    res_ready   = 2'b00;
    req_valid   = 2'b01;
    req_s[47:0] = 48'h00000000ABCD;
    req_c[47:0] = 48'h000000001111;
    #1;
    check("t5_gnt", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    nreset    = 1'b0;
    #1;
    check("t5_rst_cla_s", 64'(cla_s), 64'h0);
    step();
    nreset = 1'b1;
    step();
    check("t5_no_stale_a", 64'(res_valid), 64'h0);
    step();
    check("t5_no_stale_b", 64'(res_valid), 64'h0);
    req_valid   = 2'b01;
    req_s[47:0] = 48'h000000000005;
    req_c[47:0] = 48'hFFFFFFFFFFFF;
    #1;
    check("t5_gnt_after", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    step();
    step();
    check("t5_valid", 64'(res_valid), 64'h1);
    check("t5_sum",   64'(res_sum[47:0]), 64'h4);
    check("t5_cout",  64'(res_cout[0]), 64'h1);

    // 6a: both continuously valid and consuming
    do_reset();
    req_valid = 2'b11;
    res_ready = 2'b11;
    for (int i = 0; i < 9; i++) begin
      #1;
      check($sformatf("t6_pattern_%0d", i), 64'(req_ready), 64'(pat[i % 3]));
      step();
    end

    // 6b: both eligible after a grant to 0 -- policies disagree here
    do_reset();
    req_valid = 2'b01;
    #1;
    check("t6b_gnt0", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    step();
    step();
    req_valid = 2'b11;
    res_ready = 2'b01;
    #1;
`ifdef CLA_SHARE_ARB_FIXED_PRIO_EN
    check("t6b_policy", 64'(req_ready), 64'h1);
`else
    check("t6b_policy", 64'(req_ready), 64'h2);
`endif
    req_valid = 2'b00;
    res_ready = 2'b11;
    step();
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
